// File: rtl/pong_pkg.sv
// Shared definitions for the ping-pong match sequencer.
// Contents:
//   DEF_SCORE_W   - default score counter width
//   SERVE_RIGHT   - serve_dir value for a launch toward the right player
//   SERVE_LEFT    - serve_dir value for a launch toward the left player
//   match_state_t - match FSM state encoding (also exported on state_o)
//   point_t       - outcome of the last rally, held across the POINT cycle
package pong_pkg;

   localparam int unsigned DEF_SCORE_W = 3;

   localparam logic SERVE_RIGHT = 1'b1;
   localparam logic SERVE_LEFT  = 1'b0;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StServe = 3'd1,
      StPlay  = 3'd2,
      StPoint = 3'd3,
      StOver  = 3'd4
   } match_state_t;

   typedef enum logic [1:0] {
      PtReplay = 2'd0,
      PtLeft   = 2'd1,
      PtRight  = 2'd2
   } point_t;

endpackage

// File: rtl/serve_timer.sv
// Serve-delay down-counter, counted in frames.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   load      - load count from load_val (has priority over tick)
//   load_val  - serve delay in frames
//   tick      - frame tick, already qualified to the SERVE state by the caller
//   expire    - tick arriving while the count is already zero
module serve_timer #(
   parameter int unsigned SERVE_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [SERVE_W-1:0] load_val,
   input  logic               tick,
   output logic               expire
);

   logic [SERVE_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (tick && (count != '0)) begin
         count <= count - SERVE_W'(1);
      end
   end

   assign expire = tick && (count == '0) && !load;

endmodule

// File: rtl/pong_match_ctrl.sv
// Match sequencer for the ping-pong game: serve delay, scoring, win detection.
// Ports:
//   s_axi_aclk, s_axi_areset - clock, synchronous active-high reset
//   start            - pulse; starts or restarts a match from any state
//   pause            - level; holds engine_run low during PLAY
//   frame_tick       - pulse per frame; paces the serve delay
//   miss_l, miss_r   - pulses; ball passed the left / right paddle
//   cfg_win_score    - points to win (0 means the saturated maximum)
//   cfg_serve_frames - serve delay; a serve lasts cfg_serve_frames+1 ticks
//   engine_run       - engine may advance (PLAY and not paused)
//   ball_reset       - pulse on the first cycle of every SERVE entry
//   serve_dir        - launch direction, 1 = toward right
//   L_side_s, R_side_s - scores
//   game_over, winner  - match finished; winner 1 = right
//   state_o          - FSM state for status readback
module pong_match_ctrl
   import pong_pkg::*;
#(
   parameter int unsigned SCORE_W = DEF_SCORE_W,
   parameter int unsigned SERVE_W = 8
) (
   input  logic               s_axi_aclk,
   input  logic               s_axi_areset,
   input  logic               start,
   input  logic               pause,
   input  logic               frame_tick,
   input  logic               miss_l,
   input  logic               miss_r,
   input  logic [SCORE_W-1:0] cfg_win_score,
   input  logic [SERVE_W-1:0] cfg_serve_frames,
   output logic               engine_run,
   output logic               ball_reset,
   output logic               serve_dir,
   output logic [SCORE_W-1:0] L_side_s,
   output logic [SCORE_W-1:0] R_side_s,
   output logic               game_over,
   output logic               winner,
   output logic [2:0]         state_o
);

   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   match_state_t       state;
   point_t             point;
   logic [SCORE_W-1:0] win_eff;
   logic               point_over;
   logic               timer_load;
   logic               timer_tick;
   logic               serve_expire;

   assign win_eff = (cfg_win_score == '0) ? SCORE_MAX : cfg_win_score;

   // Only the player who just scored can have reached the win threshold.
   assign point_over = (state == StPoint) &&
                       (((point == PtRight) && (R_side_s >= win_eff)) ||
                        ((point == PtLeft)  && (L_side_s >= win_eff)));

   assign timer_load = start || ((state == StPoint) && !point_over);
   assign timer_tick = frame_tick && (state == StServe);

   serve_timer #(
      .SERVE_W (SERVE_W)
   ) u_serve_timer (
      .clk      (s_axi_aclk),
      .rst      (s_axi_areset),
      .load     (timer_load),
      .load_val (cfg_serve_frames),
      .tick     (timer_tick),
      .expire   (serve_expire)
   );

   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         state      <= StIdle;
         point      <= PtReplay;
         L_side_s   <= '0;
         R_side_s   <= '0;
         serve_dir  <= SERVE_LEFT;
         ball_reset <= 1'b0;
         game_over  <= 1'b0;
         winner     <= 1'b0;
      end else begin
         ball_reset <= 1'b0;
         // start overrides whatever the current state would do, misses included
         if (start) begin
            state      <= StServe;
            L_side_s   <= '0;
            R_side_s   <= '0;
            serve_dir  <= SERVE_LEFT;
            game_over  <= 1'b0;
            winner     <= 1'b0;
            ball_reset <= 1'b1;
         end else begin
            case (state)
               StServe: begin
                  if (serve_expire) state <= StPlay;
               end
               StPlay: begin
                  if (miss_l || miss_r) begin
                     state <= StPoint;
                     if (miss_l && miss_r) begin
                        point <= PtReplay;
                     end else if (miss_l) begin
                        point     <= PtRight;
                        serve_dir <= SERVE_RIGHT;
                        if (R_side_s != SCORE_MAX) R_side_s <= R_side_s + SCORE_W'(1);
                     end else begin
                        point     <= PtLeft;
                        serve_dir <= SERVE_LEFT;
                        if (L_side_s != SCORE_MAX) L_side_s <= L_side_s + SCORE_W'(1);
                     end
                  end
               end
               StPoint: begin
                  if (point_over) begin
                     state     <= StOver;
                     game_over <= 1'b1;
                     winner    <= (point == PtRight);
                  end else begin
                     state      <= StServe;
                     ball_reset <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign engine_run = (state == StPlay) && !pause;
   assign state_o    = state;

endmodule

// File: doc/pong_match_ctrl.md
# pong_match_ctrl

Match sequencer for the ping-pong VGA game. It sits between the AXI-lite register slice and the ball/paddle engine. It takes software start/pause controls, per-frame ticks and miss events from the engine. It drives engine run/reset, serve direction and the two 3-bit score outputs that feed `R_side_s` / `L_side_s`.

## Interface
Parameters:
- `SCORE_W`, default 3: score counter width.
- `SERVE_W`, default 8: serve-delay frame counter width.

Ports:
- `s_axi_aclk` in 1: single clock for the block.
- `s_axi_areset` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle pulse from the control register; starts or restarts a match.
- `pause` in 1: level; freezes the engine during PLAY.
- `frame_tick` in 1: one-cycle pulse per frame (VSYNC edge).
- `miss_l` in 1: one-cycle pulse; ball passed the left paddle.
- `miss_r` in 1: one-cycle pulse; ball passed the right paddle.
- `cfg_win_score` in SCORE_W: points needed to win; 0 is treated as 2^SCORE_W−1.
- `cfg_serve_frames` in SERVE_W: serve delay in frames.
- `engine_run` out 1: engine may advance ball and paddles.
- `ball_reset` out 1: one-cycle pulse; engine recentres the ball.
- `serve_dir` out 1: launch direction, 1 = toward right.
- `L_side_s` out SCORE_W: left player score.
- `R_side_s` out SCORE_W: right player score.
- `game_over` out 1: match finished.
- `winner` out 1: 1 = right won; valid only while `game_over` = 1.
- `state_o` out 3: FSM state, for status readback.

## Operation
- States: IDLE, SERVE, PLAY, POINT, OVER.
- Reset values:
  - state = IDLE.
  - All outputs 0: scores, `serve_dir`, `ball_reset`, `game_over`, `winner`.
  - Serve counter = 0.
- IDLE → SERVE on `start`.
  - Scores are cleared.
  - `serve_dir` = 0.
  - The serve counter is loaded with `cfg_serve_frames`.
- SERVE:
  - On each `frame_tick` with counter > 0, the counter decrements.
  - A `frame_tick` with counter = 0 moves to PLAY.
  - A serve therefore lasts `cfg_serve_frames`+1 ticks.
- PLAY:
  - `miss_l` gives a point to the right player: `R_side_s`+1, `serve_dir` = 1.
  - `miss_r` gives a point to the left player: `L_side_s`+1, `serve_dir` = 0.
  - Either miss moves to POINT.
  - `miss_l` and `miss_r` in the same cycle: no score change, `serve_dir` unchanged, go to POINT (replay).
  - Scores saturate at 2^SCORE_W−1.
- POINT lasts one cycle.
  - If the updated scorer's score ≥ effective win score: go to OVER, set `game_over` = 1, `winner` = the scorer.
  - Otherwise go to SERVE and reload the counter.
  - On a replay: always go to SERVE.
- OVER:
  - Scores and `winner` are held.
  - `start` clears scores and `game_over`, sets `serve_dir` = 0, and moves to SERVE.
- `start` in SERVE, PLAY or POINT aborts the match and restarts it exactly as from IDLE.
- Misses are ignored outside PLAY.
- `frame_tick` is ignored outside SERVE.
- `engine_run` = (state == PLAY) & ~`pause`, combinational from the state register.
- Misses are honoured in PLAY even while paused.

## Timing
- `start` sampled in cycle N → in cycle N+1: state = SERVE, scores = 0, `ball_reset` = 1 for exactly this cycle.
- Miss sampled in cycle N (PLAY):
  - Cycle N+1: state = POINT, score updated, `engine_run` = 0.
  - Cycle N+2: state = SERVE with `ball_reset` = 1, or state = OVER with `game_over` = 1.
- Final `frame_tick` of the serve sampled in cycle N → state = PLAY in cycle N+1; `engine_run` rises in N+1 if unpaused.
- `ball_reset` is registered. It asserts only in the first cycle of every SERVE entry and never stays high for two consecutive cycles.
- A synchronous reset mid-match returns all outputs to their reset values on the next edge, with no `ball_reset` pulse.
- `start` and a miss in the same cycle: `start` wins.

## Structure
- Shared package `pong_pkg` holds:
  - the `match_state_t` enum: IDLE = 0, SERVE = 1, PLAY = 2, POINT = 3, OVER = 4;
  - `SERVE_RIGHT` / `SERVE_LEFT` constants;
  - the default `SCORE_W`.
- One sub-module, `serve_timer`, holds the SERVE_W-bit down-counter. It has load, `frame_tick` decrement and `expire` (tick at zero) ports.
- The FSM, score registers and output decode live in the top level.

## Test plan
- Reset, then `start`: next cycle state = SERVE, `ball_reset` = 1 for one cycle, scores 0/0. With `cfg_serve_frames` = 2, PLAY begins after the 3rd `frame_tick`.
- `miss_r` in PLAY: `L_side_s` = 1, `serve_dir` = 0, state sequence POINT → SERVE, `ball_reset` pulses in the SERVE cycle.
- `cfg_win_score` = 3 and `miss_l` ×3: `R_side_s` = 3, state = OVER, `game_over` = 1, `winner` = 1. Further misses do not change the scores.
- `miss_l` and `miss_r` in the same cycle: scores unchanged, `serve_dir` unchanged, re-serve.
- `pause` high in PLAY: `engine_run` = 0 in the same cycle. Pause low: `engine_run` = 1. A miss while paused still scores.
- `start` mid-PLAY with scores 2/1: next cycle scores 0/0 and state = SERVE. A synchronous reset mid-SERVE returns state = IDLE with all outputs 0.
